// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//   Two requesters (0 = fetch PC+4, 1 = branch target) share one adder. The
//   single-entry result register accepts one operand pair per cycle and
//   reports a wrapped two's-complement sum plus a signed-overflow flag.
//
//   Contention policy is selected at build time:
//     ADDER_ARB_RR_EN defined   -> round-robin. The last requester served
//                                  loses the next contest.
//     ADDER_ARB_RR_EN undefined -> fixed priority. Requester 1 always wins.
//
// Parameters
//   DATA_W      operand / result width in bits
//
// Ports
//   Clk         rising-edge clock
//   Rst         synchronous active-high reset
//   req0_valid  requester 0 has operands pending
//   req0_a/_b   requester 0 operands (two's complement)
//   req0_ready  requester 0 operands accepted this cycle
//   req1_valid  requester 1 has operands pending
//   req1_a/_b   requester 1 operands (two's complement)
//   req1_ready  requester 1 operands accepted this cycle
//   res_valid   result register occupied
//   res_id      requester that owns the result
//   res_data    registered sum
//   res_ovf     registered signed-overflow flag
//   res_ready   consumer takes the result this cycle
// -----------------------------------------------------------------------------
module adder_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,
  output logic              res_valid,
  output logic              res_id,
  output logic [DATA_W-1:0] res_data,
  output logic              res_ovf,
  input  logic              res_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  // Signed overflow: operands agree in sign but the wrapped sum does not.
  function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] s);
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

  state_t                    state_q, state_d;
  logic                      res_id_q, res_id_d;
  logic signed [DATA_W-1:0]  res_data_q, res_data_d;
  logic                      res_ovf_q, res_ovf_d;

  logic                      free;
  logic                      grant;
  logic                      xfer;
  logic signed [DATA_W-1:0]  op_a;
  logic signed [DATA_W-1:0]  op_b;
  logic signed [DATA_W-1:0]  sum;

`ifdef ADDER_ARB_RR_EN
  logic                      last_grant_q, last_grant_d;
`endif

  // Grant selection: a lone requester always wins; contests follow the
  // configured policy.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ADDER_ARB_RR_EN
      grant = ~last_grant_q;
`else
      grant = 1'b1;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Slot is free when empty or being drained this cycle. Reset blocks any
  // handshake so nothing is accepted in a reset cycle.
  always_comb begin
    free       = (state_q == EMPTY) || res_ready;
    req0_ready = !Rst && free && req0_valid && !grant;
    req1_ready = !Rst && free && req1_valid &&  grant;
    xfer       = req0_ready || req1_ready;
  end

  // Shared adder, operands muxed by the grant.
  always_comb begin
    op_a = grant ? signed'(req1_a) : signed'(req0_a);
    op_b = grant ? signed'(req1_b) : signed'(req0_b);
    sum  = op_a + op_b;
  end

  // Next-state / result update
  always_comb begin
    state_d    = state_q;
    res_id_d   = res_id_q;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;
    if (xfer) begin
      state_d    = FULL;
      res_id_d   = grant;
      res_data_d = sum;
      res_ovf_d  = add_ovf(op_a, op_b, sum);
    end else if (res_ready) begin
      // Drain: data/id/ovf keep their last values.
      state_d    = EMPTY;
    end
  end

`ifdef ADDER_ARB_RR_EN
  always_comb begin
    last_grant_d = last_grant_q;
    if (xfer) begin
      last_grant_d = grant;
    end
  end

  // last_grant resets to 1 so requester 0 wins the first contest.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Result register stage
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= EMPTY;
      res_id_q   <= 1'b0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_id_q   <= res_id_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

  localparam int DATA_W = 32;

  logic              Clk;
  logic              Rst;
  logic              req0_valid;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              req1_ready;
  logic              res_valid;
  logic              res_id;
  logic [DATA_W-1:0] res_data;
  logic              res_ovf;
  logic              res_ready;

  int n_cmp = 0;
  int n_err = 0;

  adder_arbiter #(.DATA_W(DATA_W)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_data   (res_data),
    .res_ovf    (res_ovf),
    .res_ready  (res_ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after
  // the rising edge (registered) or 1 unit after driving (combinational).
  task automatic wait_rise();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_idle();
    @(negedge Clk);
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    res_ready  = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    wait_rise();
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    res_ready  = 1'b1;
    wait_rise();
    wait_rise();
    // Requests during reset must not be accepted.
    @(negedge Clk);
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_readies: got %b%b want 00", req0_ready, req1_ready);
    end
    wait_rise();
    n_cmp++;
    if (res_valid !== 1'b0 || res_id !== 1'b0 || res_data !== 32'h0 || res_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b id=%b d=%h o=%b want v=0 id=0 d=0 o=0",
               res_valid, res_id, res_data, res_ovf);
    end
    @(negedge Clk);
    Rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single_add();
    @(negedge Clk);
    req0_valid = 1'b1; req0_a = 32'h0000_0004; req0_b = 32'h0040_0000;
    res_ready = 1'b1;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready);
    end
    wait_rise();
    n_cmp++;
    if (res_valid !== 1'b1 || res_id !== 1'b0 || res_data !== 32'h0040_0004 || res_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL single_add: got v=%b id=%b d=%h o=%b want v=1 id=0 d=00400004 o=0",
               res_valid, res_id, res_data, res_ovf);
    end
    drive_idle();
    wait_rise();
    n_cmp++;
    if (res_valid !== 1'b0 || res_data !== 32'h0040_0004) begin
      n_err++;
      $display("FAIL drain: got v=%b d=%h want v=0 d=00400004", res_valid, res_data);
    end
  endtask

  task automatic test_signed_add();
    @(negedge Clk);
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFF8; req1_b = 32'h0000_0010;
    res_ready = 1'b1;
    wait_rise();
    n_cmp++;
    if (res_valid !== 1'b1 || res_id !== 1'b1 || res_data !== 32'h0000_0008 || res_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL signed_add: got v=%b id=%b d=%h o=%b want v=1 id=1 d=00000008 o=0",
               res_valid, res_id, res_data, res_ovf);
    end
    drive_idle();
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] va [3];
    logic [DATA_W-1:0] vb [3];
    logic [DATA_W-1:0] vs [3];
    logic              vo [3];
    va[0] = 32'h7FFF_FFFF; vb[0] = 32'h0000_0001; vs[0] = 32'h8000_0000; vo[0] = 1'b1;
    va[1] = 32'h8000_0000; vb[1] = 32'hFFFF_FFFF; vs[1] = 32'h7FFF_FFFF; vo[1] = 1'b1;
    va[2] = 32'h7FFF_FFFF; vb[2] = 32'h8000_0000; vs[2] = 32'hFFFF_FFFF; vo[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      req0_valid = 1'b1; req0_a = va[i]; req0_b = vb[i];
      res_ready = 1'b1;
      wait_rise();
      n_cmp++;
      if (res_data !== vs[i] || res_ovf !== vo[i] || res_id !== 1'b0) begin
        n_err++;
        $display("FAIL overflow_%0d: got d=%h o=%b id=%b want d=%h o=%b id=0",
                 i, res_data, res_ovf, res_id, vs[i], vo[i]);
      end
    end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      req0_valid = 1'b1; req0_a = 32'(100 * (i + 1)); req0_b = 32'(i + 1);
      res_ready = 1'b1;
      wait_rise();
      n_cmp++;
      if (res_valid !== 1'b1 || res_data !== 32'(101 * (i + 1))) begin
        n_err++;
        $display("FAIL back_to_back_%0d: got v=%b d=%0d want v=1 d=%0d",
                 i, res_valid, res_data, 101 * (i + 1));
      end
    end
    drive_idle();
  endtask

  task automatic test_contention();
    logic exp_id [4];
`ifdef ADDER_ARB_RR_EN
    exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0; exp_id[3] = 1'b1;
`else
    exp_id[0] = 1'b1; exp_id[1] = 1'b1; exp_id[2] = 1'b1; exp_id[3] = 1'b1;
`endif
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd1;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_rise();
      n_cmp++;
      if (res_valid !== 1'b1 || res_id !== exp_id[i] ||
          res_data !== (exp_id[i] ? 32'd30 : 32'd2)) begin
        n_err++;
        $display("FAIL contention_%0d: got v=%b id=%b d=%0d want v=1 id=%b d=%0d",
                 i, res_valid, res_id, res_data, exp_id[i], exp_id[i] ? 30 : 2);
      end
    end
    drive_idle();
  endtask

  task automatic test_backpressure();
    drive_idle();
    wait_rise();
    @(negedge Clk);
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd6;
    res_ready = 1'b0;
    wait_rise();
    n_cmp++;
    if (res_valid !== 1'b1 || res_data !== 32'd11) begin
      n_err++;
      $display("FAIL bp_load: got v=%b d=%0d want v=1 d=11", res_valid, res_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      // Operands wander while stalled; none of these may be captured.
      req0_a = 32'(1000 + i); req0_b = 32'(7 * i);
      req1_valid = (i == 1);
      req1_a = 32'd9; req1_b = 32'd9;
      #1;
      n_cmp++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_ready_%0d: got %b%b want 00", i, req0_ready, req1_ready);
      end
      wait_rise();
      n_cmp++;
      if (res_valid !== 1'b1 || res_id !== 1'b0 || res_data !== 32'd11 || res_ovf !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got v=%b id=%b d=%0d o=%b want v=1 id=0 d=11 o=0",
                 i, res_valid, res_id, res_data, res_ovf);
      end
    end
    @(negedge Clk);
    req1_valid = 1'b0;
    req0_a = 32'd100; req0_b = 32'd200;
    res_ready = 1'b1;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release_ready: got %b want 1", req0_ready);
    end
    wait_rise();
    n_cmp++;
    if (res_valid !== 1'b1 || res_id !== 1'b0 || res_data !== 32'd300) begin
      n_err++;
      $display("FAIL bp_release: got v=%b id=%b d=%0d want v=1 id=0 d=300",
               res_valid, res_id, res_data);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_stall();
    logic exp_id;
`ifdef ADDER_ARB_RR_EN
    exp_id = 1'b0;
`else
    exp_id = 1'b1;
`endif
    // Leave last_grant at 0 in RR mode so only a working reset restores req0.
    @(negedge Clk);
    req0_valid = 1'b1; req0_a = 32'h0000_1000; req0_b = 32'h0000_0234;
    res_ready = 1'b0;
    wait_rise();
    n_cmp++;
    if (res_valid !== 1'b1 || res_data !== 32'h0000_1234) begin
      n_err++;
      $display("FAIL rst_stall_load: got v=%b d=%h want v=1 d=00001234", res_valid, res_data);
    end
    @(negedge Clk);
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd7;
    res_ready = 1'b1;
    Rst = 1'b1;
    wait_rise();
    n_cmp++;
    if (res_valid !== 1'b0 || res_data !== 32'h0 || res_id !== 1'b0 || res_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL rst_stall_clear: got v=%b id=%b d=%h o=%b want v=0 id=0 d=0 o=0",
               res_valid, res_id, res_data, res_ovf);
    end
    @(negedge Clk);
    Rst = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4;
    res_ready = 1'b1;
    wait_rise();
    n_cmp++;
    if (res_valid !== 1'b1 || res_id !== exp_id || res_data !== (exp_id ? 32'd7 : 32'd3)) begin
      n_err++;
      $display("FAIL rst_stall_contest: got v=%b id=%b d=%0d want v=1 id=%b d=%0d",
               res_valid, res_id, res_data, exp_id, exp_id ? 7 : 3);
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_signed_add();
    test_overflow();
    test_back_to_back();
    test_contention();
    test_backpressure();
    // One more req0 op so round-robin state points away from requester 0.
    @(negedge Clk);
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; res_ready = 1'b1;
    wait_rise();
    drive_idle();
    wait_rise();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
